// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: base opcodes and issue scoreboard FSM states.
// Used by reg_use_decode and issue_scoreboard.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  typedef enum logic {
    SB_RUN     = 1'b0,
    SB_BR_WAIT = 1'b1
  } sb_state_t;

endpackage

// File: rtl/reg_use_decode.sv
// Opcode-based register usage decode: which of rs1/rs2/rd an instruction
// touches, and whether it is a control transfer.
module reg_use_decode
  import riscv_pkg::*;
(
  input  logic [31:0] ir,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic        writes_rd,
  output logic        is_ctrl
);

  logic [6:0] op;
  logic       unused_ir;

  assign op        = ir[6:0];
  assign unused_ir = ^ir[31:7];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    is_ctrl   = 1'b0;
    unique case (1'b1)
      (op == OPC_LOAD): begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      (op == OPC_STORE): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      (op == OPC_OP || op == OPC_OP_32): begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      (op == OPC_OP_IMM || op == OPC_OP_IMM_32): begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      (op == OPC_BRANCH): begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        is_ctrl = 1'b1;
      end
      (op == OPC_JALR): begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
        is_ctrl   = 1'b1;
      end
      (op == OPC_JAL): begin
        writes_rd = 1'b1;
        is_ctrl   = 1'b1;
      end
      (op == OPC_LUI || op == OPC_AUIPC): begin
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue control with per-register pending-write counters and branch hold.
// Optional ISSUE_SB_WB_BYPASS_EN lets a source retiring this cycle issue.
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int PEND_W = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DE_V,
  input  logic [31:0] DE_IR,
  input  logic        EXE_READY,
  input  logic        WB_V,
  input  logic [4:0]  WB_DR,
  input  logic        BR_RESOLVE,
  input  logic        FLUSH,
  output logic        ISSUE,
  output logic        STALL,
  output logic        FE_STALL,
  output logic [31:0] PEND_MASK,
  output logic        SB_ERR
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt [32];
  logic [31:0]       inc;
  logic [31:0]       dec;
  sb_state_t         state, state_nx;

  logic       use_rs1, use_rs2, writes_rd, is_ctrl;
  logic [4:0] rs1, rs2, rd;
  logic       byp1, byp2;
  logic       raw, sat, hazard;

  reg_use_decode u_dec (
    .ir        (DE_IR),
    .use_rs1   (use_rs1),
    .use_rs2   (use_rs2),
    .writes_rd (writes_rd),
    .is_ctrl   (is_ctrl)
  );

  assign rs1 = DE_IR[19:15];
  assign rs2 = DE_IR[24:20];
  assign rd  = DE_IR[11:7];

`ifdef ISSUE_SB_WB_BYPASS_EN
  // Last outstanding write lands this cycle; the RF writes through.
  assign byp1 = WB_V && WB_DR == rs1 && cnt[rs1] == CNT_ONE;
  assign byp2 = WB_V && WB_DR == rs2 && cnt[rs2] == CNT_ONE;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    raw = 1'b0;
    if (use_rs1 && rs1 != 5'd0 && cnt[rs1] != '0 && !byp1)
      raw = 1'b1;
    if (use_rs2 && rs2 != 5'd0 && cnt[rs2] != '0 && !byp2)
      raw = 1'b1;
  end

  assign sat    = writes_rd && rd != 5'd0 && cnt[rd] == CNT_MAX;
  assign hazard = raw || sat;

  assign ISSUE = DE_V && EXE_READY && !hazard
              && state == SB_RUN && !FLUSH;
  assign STALL = DE_V && !ISSUE;
  assign FE_STALL = state == SB_BR_WAIT || (DE_V && is_ctrl);

  always_comb begin
    inc       = '0;
    dec       = '0;
    PEND_MASK = '0;
    for (int i = 0; i < 32; i++) begin
      inc[i] = ISSUE && writes_rd && rd == 5'(i) && i != 0;
      dec[i] = WB_V && WB_DR == 5'(i) && cnt[i] != '0;
      PEND_MASK[i] = cnt[i] != '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (inc[i] && !dec[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec[i] && !inc[i])
          cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      SB_ERR <= 1'b0;
    else if (!FLUSH && WB_V && cnt[WB_DR] == '0)
      SB_ERR <= 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= SB_RUN;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (FLUSH) begin
      state_nx = SB_RUN;
    end else begin
      unique case (state)
        SB_RUN:     if (ISSUE && is_ctrl) state_nx = SB_BR_WAIT;
        SB_BR_WAIT: if (BR_RESOLVE)       state_nx = SB_RUN;
        default:    state_nx = SB_RUN;
      endcase
    end
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue controller sitting beside the decode stage. It decides each cycle whether the instruction in decode may issue to execute, and tracks in-flight destination registers in a per-register pending-write scoreboard. It also holds fetch while an unresolved control-transfer instruction is in flight. It replaces pairwise comparison of a decode instruction against the EXE/MEM/WB destination registers with counted tracking that is correct for any pipeline depth.

## Interface
- PEND_W, 2: width of each per-register pending-write counter; max in-flight writes per register = 2^PEND_W - 1.
- CLK  in  1  clock; all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DE_V  in  1  decode holds a valid instruction.
- DE_IR  in  32  decode instruction word.
- EXE_READY  in  1  execute can accept an instruction this cycle.
- WB_V  in  1  writeback retiring a register write this cycle.
- WB_DR  in  5  writeback destination register.
- BR_RESOLVE  in  1  execute resolved the outstanding control instruction (one-cycle pulse).
- FLUSH  in  1  pipeline-wide kill of all in-flight instructions.
- ISSUE  out  1  decode instruction transfers to execute this cycle.
- STALL  out  1  decode valid but not issuing.
- FE_STALL  out  1  fetch must hold.
- PEND_MASK  out  32  bit r set when register r's counter is nonzero.
- SB_ERR  out  1  sticky: writeback to a register with zero pending count.

## Operation
- Register use is decoded from opcode DE_IR[6:0]:
  - LOAD 0000011: rs1, rd.
  - STORE 0100011: rs1, rs2.
  - OP 0110011 and OP-32 0111011: rs1, rs2, rd.
  - OP-IMM 0010011 and OP-IMM-32 0011011: rs1, rd.
  - BRANCH 1100011: rs1, rs2.
  - JALR 1100111: rs1, rd.
  - JAL 1101111, LUI 0110111, AUIPC 0010111: rd only.
  - Any other opcode: no registers, always issues.
- x0 is never a source hazard and is never counted as a destination.
- RAW hazard: a used source register has a nonzero counter.
- Saturation hazard: the destination register's counter equals 2^PEND_W - 1.
- ISSUE = DE_V & EXE_READY & ~hazard & state==RUN & ~FLUSH.
- STALL = DE_V & ~ISSUE.
- Counter update per register r, next cycle:
  - +1 if ISSUE and the instruction writes r.
  - -1 if WB_V and WB_DR==r and the count is nonzero.
  - Both on the same register in the same cycle: count unchanged.
  - WB_V to a register with count 0: counter unchanged, SB_ERR set.
- FSM states:
  - RUN: ISSUE of BRANCH, JAL or JALR moves to BR_WAIT.
  - BR_WAIT: no issue allowed; BR_RESOLVE returns to RUN.
- FE_STALL = (state==BR_WAIT) | (DE_V & DE_IR[6:0] is BRANCH/JAL/JALR).
- FLUSH has highest priority: all counters go to 0, state goes to RUN, ISSUE is 0 that cycle, SB_ERR is unchanged. WB_V in the same cycle is ignored.
- BR_RESOLVE while in RUN is ignored.

## Timing
- ISSUE, STALL and FE_STALL are combinational from the current inputs and state.
- Counters, state and SB_ERR are registered. PEND_MASK is derived from the registered counters.
- Reset values: all counters 0, state RUN, PEND_MASK 0, SB_ERR 0. Outputs then follow inputs combinationally.
- Issue-to-dependent latency: a consumer of rd issues at the earliest in the cycle after the WB_V for that rd (without the config macro).
- Control instruction: fetch is held from the decode cycle through the BR_RESOLVE cycle; the next issue occurs at the earliest one cycle after BR_RESOLVE.
- Asserting RESET_N low mid-operation clears state immediately, asynchronously.

## Configuration
- ISSUE_SB_WB_BYPASS_EN defined: a source whose counter is 1 and which is retiring this cycle (WB_V & WB_DR match) is not a hazard. This relies on register-file write-through, so the consumer issues in the same cycle as the writeback.
- ISSUE_SB_WB_BYPASS_EN undefined: any nonzero counter stalls.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - FSM enum sb_state_t {SB_RUN, SB_BR_WAIT}.
- One combinational sub-module, reg_use_decode: takes DE_IR and produces use_rs1, use_rs2, writes_rd and is_ctrl. The decode stage can reuse it.
- The counter array and FSM live in issue_scoreboard.

## Test plan
- Reset, then issue ADD x5,x1,x2 with EXE_READY=1 -> ISSUE=1; the next cycle PEND_MASK[5]=1.
- ADD x5, then SUB x6,x5,x1 -> STALL=1 until WB_V with WB_DR=5. Without the macro, ISSUE occurs one cycle after WB; with ISSUE_SB_WB_BYPASS_EN, ISSUE occurs in the WB cycle.
- Three back-to-back writes to x7 with PEND_W=2 -> the third issues (count reaches 3); a fourth stalls until one WB to x7.
- BEQ issues -> FE_STALL=1 and an ADD in decode stalls until the BR_RESOLVE pulse; ISSUE occurs in the following cycle.
- Same cycle: issue writing x9 and WB_V with WB_DR=9 at count 1 -> count stays 1. WB to x3 at count 0 -> SB_ERR=1 and it remains set.
- FLUSH in BR_WAIT with PEND_MASK=0x0000_0060 -> the next cycle PEND_MASK=0, state RUN, FE_STALL=0 when no control instruction is in decode.
